// File: rtl/result_sender.sv
// result_sender: per-PU result packetiser and transmitter.
//
// Buffers variable-length result records from one processing unit as complete
// packets. When the collector pulses `start`, one packet is streamed: a
// length header word (total packet words, header included) followed by the
// payload words in write order.
//
// Ports:
//   sys_clk  - clock, all logic on the rising edge
//   sys_rst  - synchronous active-high reset
//   wr_vld   - producer word valid
//   wr_data  - producer payload word
//   wr_last  - final word of a record (qualified by wr_vld)
//   wr_rdy   - word accepted when wr_vld && wr_rdy (registered)
//   start    - one-cycle request to send one packet
//   empty    - no complete packet queued (registered)
//   vld      - output word valid
//   eop      - last word of a packet
//   data     - output word, holds its value while vld is low
//   busy     - a packet is being transmitted
//   err_ovf  - sticky: a record exceeded 254 payload words
module result_sender #(
    parameter int unsigned DW        = 64,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned PKT_DEPTH = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          wr_rdy,
    input  logic          start,
    output logic          empty,
    output logic          vld,
    output logic          eop,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          err_ovf
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned QW  = $clog2(PKT_DEPTH);
    localparam int unsigned QCW = QW + 1;

    localparam logic [CW-1:0]  BUF_FULL = CW'(DEPTH);
    localparam logic [QCW-1:0] PKT_FULL = QCW'(PKT_DEPTH);
    localparam logic [7:0]     MAX_LEN  = 8'd254;

    typedef enum logic [1:0] {StIdle, StHdr, StPay} state_t;

    // Storage
    logic [DW-1:0] buf_mem [DEPTH];
    logic [7:0]    pq_mem  [PKT_DEPTH];

    // Write side state
    logic [AW-1:0]  wr_ptr;
    logic [QW-1:0]  pq_wr;
    logic [7:0]     wcnt;
    logic [CW-1:0]  buf_cnt;
    logic [QCW-1:0] pkt_cnt;

    // Read side state
    state_t        state;
    logic [AW-1:0] rd_ptr;
    logic [QW-1:0] pq_rd;
    logic [7:0]    rem;

    // Next-state helpers
    logic           wr_acc;
    logic           buf_wr;
    logic           buf_rd;
    logic           pq_push;
    logic           pq_pop;
    logic [7:0]     push_len;
    logic [CW-1:0]  buf_cnt_d;
    logic [QCW-1:0] pkt_cnt_d;

    always_comb begin
        wr_acc    = wr_vld && wr_rdy;
        // Words past the 254th of a record are acknowledged but dropped.
        buf_wr    = wr_acc && (wcnt != MAX_LEN);
        pq_push   = wr_acc && wr_last;
        push_len  = (wcnt == MAX_LEN) ? MAX_LEN : wcnt + 8'd1;
        pq_pop    = (state == StIdle) && start && !empty;
        // One buffer read per payload word: in HDR for word 1, in PAY while words remain.
        buf_rd    = (state == StHdr) || ((state == StPay) && (rem != 8'd0));
        buf_cnt_d = buf_cnt + CW'(buf_wr) - CW'(buf_rd);
        pkt_cnt_d = pkt_cnt + QCW'(pq_push) - QCW'(pq_pop);
    end

    // Write side bookkeeping and registered status flags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr  <= '0;
            pq_wr   <= '0;
            wcnt    <= 8'd0;
            buf_cnt <= '0;
            pkt_cnt <= '0;
            wr_rdy  <= 1'b0;
            empty   <= 1'b1;
            err_ovf <= 1'b0;
        end else begin
            if (buf_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (wr_acc) begin
                if (wr_last) begin
                    wcnt <= 8'd0;
                end else if (wcnt != MAX_LEN) begin
                    wcnt <= wcnt + 8'd1;
                end
                if (wcnt == MAX_LEN) begin
                    err_ovf <= 1'b1;
                end
            end
            if (pq_push) begin
                pq_wr <= pq_wr + QW'(1);
            end
            buf_cnt <= buf_cnt_d;
            pkt_cnt <= pkt_cnt_d;
            // Registered from next-state counts so there is no path from wr_vld.
            wr_rdy  <= (buf_cnt_d < BUF_FULL) && (pkt_cnt_d < PKT_FULL);
            empty   <= (pkt_cnt_d == '0);
        end
    end

    // Payload and length storage, no reset
    always_ff @(posedge sys_clk) begin
        if (buf_wr && !sys_rst) begin
            buf_mem[wr_ptr] <= wr_data;
        end
        if (pq_push && !sys_rst) begin
            pq_mem[pq_wr] <= push_len;
        end
    end

    // Transmit FSM; data is read from the buffer one cycle ahead of display
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= StIdle;
            rd_ptr <= '0;
            pq_rd  <= '0;
            rem    <= 8'd0;
            vld    <= 1'b0;
            eop    <= 1'b0;
            data   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pq_pop) begin
                        rem   <= pq_mem[pq_rd];
                        pq_rd <= pq_rd + QW'(1);
                        vld   <= 1'b1;
                        eop   <= 1'b0;
                        data  <= {{(DW-8){1'b0}}, pq_mem[pq_rd] + 8'd1};
                        state <= StHdr;
                    end
                end
                StHdr: begin
                    data   <= buf_mem[rd_ptr];
                    rd_ptr <= rd_ptr + AW'(1);
                    rem    <= rem - 8'd1;
                    eop    <= (rem == 8'd1);
                    state  <= StPay;
                end
                StPay: begin
                    if (rem != 8'd0) begin
                        data   <= buf_mem[rd_ptr];
                        rd_ptr <= rd_ptr + AW'(1);
                        rem    <= rem - 8'd1;
                        eop    <= (rem == 8'd1);
                    end else begin
                        vld   <= 1'b0;
                        eop   <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_result_sender.sv
// Bench for result_sender: a packet-level model (word FIFO, length FIFO,
// outgoing word stream) predicts every output each cycle, and directed tests
// pin the model with hand-computed packet contents.
module tb_result_sender;

    localparam int DW        = 64;
    localparam int DEPTH     = 1024;
    localparam int PKT_DEPTH = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          wr_vld  = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          start   = 1'b0;
    logic          wr_rdy;
    logic          empty;
    logic          vld;
    logic          eop;
    logic [DW-1:0] data;
    logic          busy;
    logic          err_ovf;

    always #5 sys_clk = ~sys_clk;

    result_sender #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .PKT_DEPTH (PKT_DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_vld  (wr_vld),
        .wr_data (wr_data),
        .wr_last (wr_last),
        .wr_rdy  (wr_rdy),
        .start   (start),
        .empty   (empty),
        .vld     (vld),
        .eop     (eop),
        .data    (data),
        .busy    (busy),
        .err_ovf (err_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_words[$];   // stored payload words, oldest first
    int          m_lens[$];    // lengths of complete queued packets
    logic [63:0] s_data[$];    // words still to appear on the output
    bit          s_eop[$];
    int          m_part = 0;   // stored words of the open record
    int          m_n    = 0;
    bit          m_rdy  = 0;
    bit          e_vld  = 0;
    bit          e_eop  = 0;
    bit          e_err  = 0;
    logic [63:0] e_data = '0;
    bit          chk_en = 0;

    task automatic model_step();
        if (sys_rst) begin
            m_words.delete();
            m_lens.delete();
            s_data.delete();
            s_eop.delete();
            m_part = 0;
            m_rdy  = 0;
            e_vld  = 0;
            e_eop  = 0;
            e_data = '0;
            e_err  = 0;
            chk_en = 1;
        end else begin
            // A start is honoured only when nothing is on the wire and a packet is queued.
            if (start && !e_vld && m_lens.size() > 0) begin
                m_n = m_lens.pop_front();
                s_data.push_back(64'(m_n + 1));
                s_eop.push_back(1'b0);
                for (int i = 0; i < m_n; i++) begin
                    s_data.push_back(m_words.pop_front());
                    s_eop.push_back(i == m_n - 1);
                end
            end
            if (wr_vld && m_rdy) begin
                if (m_part < 254) begin
                    m_words.push_back(wr_data);
                    m_part++;
                end else begin
                    e_err = 1;
                end
                if (wr_last) begin
                    m_lens.push_back(m_part);
                    m_part = 0;
                end
            end
            if (s_data.size() > 0) begin
                e_vld  = 1;
                e_data = s_data.pop_front();
                e_eop  = s_eop.pop_front();
            end else begin
                e_vld = 0;
                e_eop = 0;
            end
            m_rdy = (m_words.size() + s_data.size() < DEPTH) && (m_lens.size() < PKT_DEPTH);
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    // ---------------- per-cycle compare + output log ----------------
    logic [63:0] got_data[$];
    bit          got_eop[$];

    initial forever begin
        @(negedge sys_clk);
        if (chk_en) begin
            check("vld",     vld,     e_vld);
            check("eop",     eop,     e_eop);
            check("data",    data,    e_data);
            check("busy",    busy,    e_vld);
            check("empty",   empty,   m_lens.size() == 0);
            check("wr_rdy",  wr_rdy,  m_rdy);
            check("err_ovf", err_ovf, e_err);
            if (vld) begin
                got_data.push_back(data);
                got_eop.push_back(eop);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wr_word(input logic [63:0] d, input logic l);
        int guard = 0;
        wr_vld  = 1'b1;
        wr_data = d;
        wr_last = l;
        while (!wr_rdy && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        check("wr_rdy_wait", wr_rdy, 1'b1);
        @(negedge sys_clk);
        wr_vld  = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        got_data.delete();
        got_eop.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int k;

        // Reset
        cyc(3);
        check("rst_rdy",   wr_rdy,  1'b0);
        check("rst_empty", empty,   1'b1);
        check("rst_vld",   vld,     1'b0);
        check("rst_data",  data,    64'h0);
        check("rst_busy",  busy,    1'b0);
        sys_rst = 1'b0;
        cyc(1);
        check("rst_rdy_up", wr_rdy, 1'b1);

        // Single packet
        clear_log();
        wr_word(64'hA, 1'b0);
        wr_word(64'hB, 1'b0);
        check("t1_empty_before", empty, 1'b1);
        wr_word(64'hC, 1'b1);
        check("t1_empty_fall", empty, 1'b0);
        pulse_start();
        cyc(6);
        check("t1_len", got_data.size(), 4);
        if (got_data.size() == 4) begin
            check("t1_hdr", got_data[0], 64'h4);
            check("t1_w1",  got_data[1], 64'hA);
            check("t1_w2",  got_data[2], 64'hB);
            check("t1_w3",  got_data[3], 64'hC);
            check("t1_eop_mid",  got_eop[2], 1'b0);
            check("t1_eop_last", got_eop[3], 1'b1);
        end
        check("t1_empty_after", empty, 1'b1);

        // Queued packets and ignored start
        clear_log();
        wr_word(64'h11, 1'b1);
        for (int i = 0; i < 5; i++) wr_word(64'(32'h21 + i), i == 4);
        start = 1'b1;
        @(negedge sys_clk);
        check("t2_cnt1", empty, 1'b0);
        @(negedge sys_clk);
        start = 1'b0;
        check("t2_ignored", empty, 1'b0);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("t2_cnt0", empty, 1'b1);
        cyc(8);
        check("t2_len", got_data.size(), 8);
        if (got_data.size() == 8) begin
            check("t2_hdr1", got_data[0], 64'h2);
            check("t2_p1",   got_data[1], 64'h11);
            check("t2_hdr2", got_data[2], 64'h6);
            check("t2_p2a",  got_data[3], 64'h21);
            check("t2_p2e",  got_data[7], 64'h25);
            check("t2_eop",  got_eop[7],  1'b1);
        end

        // Start when empty
        clear_log();
        wr_word(64'h31, 1'b0);
        wr_word(64'h32, 1'b0);
        pulse_start();
        cyc(3);
        check("t3_no_vld", got_data.size(), 0);
        check("t3_empty",  empty, 1'b1);
        wr_word(64'h33, 1'b1);
        check("t3_empty_fall", empty, 1'b0);
        pulse_start();
        cyc(6);
        check("t3_len", got_data.size(), 4);
        if (got_data.size() == 4) begin
            check("t3_hdr", got_data[0], 64'h4);
            check("t3_w1",  got_data[1], 64'h31);
            check("t3_w3",  got_data[3], 64'h33);
        end

        // Full length queue
        clear_log();
        for (int i = 0; i < 16; i++) wr_word(64'(32'h100 + i), 1'b1);
        check("t4_rdy_low", wr_rdy, 1'b0);
        pulse_start();
        k = 0;
        while (!wr_rdy && k < 2) begin
            @(negedge sys_clk);
            k++;
        end
        check("t4_rdy_back", wr_rdy, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cyc(2);
            pulse_start();
        end
        cyc(4);
        check("t4_len", got_data.size(), 32);
        if (got_data.size() == 32) begin
            check("t4_hdr",   got_data[0],  64'h2);
            check("t4_first", got_data[1],  64'h100);
            check("t4_last",  got_data[31], 64'h10F);
        end
        check("t4_empty", empty, 1'b1);

        // Overflow record
        clear_log();
        for (int i = 0; i < 300; i++) wr_word(64'(32'h5000 + i), i == 299);
        check("t5_err", err_ovf, 1'b1);
        pulse_start();
        cyc(260);
        check("t5_len", got_data.size(), 255);
        if (got_data.size() == 255) begin
            check("t5_hdr",      got_data[0],   64'hFF);
            check("t5_first",    got_data[1],   64'h5000);
            check("t5_last",     got_data[254], 64'h50FD);
            check("t5_eop_pre",  got_eop[253],  1'b0);
            check("t5_eop_last", got_eop[254],  1'b1);
        end

        // Reset mid-packet
        for (int i = 0; i < 10; i++) wr_word(64'(32'h600 + i), i == 9);
        pulse_start();
        cyc(3);
        check("t6_mid_vld", vld, 1'b1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6_abort_vld",   vld,     1'b0);
        check("t6_abort_eop",   eop,     1'b0);
        check("t6_abort_empty", empty,   1'b1);
        check("t6_abort_err",   err_ovf, 1'b0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        clear_log();
        wr_word(64'h71, 1'b0);
        wr_word(64'h72, 1'b1);
        pulse_start();
        cyc(5);
        check("t6_len", got_data.size(), 3);
        if (got_data.size() == 3) begin
            check("t6_hdr", got_data[0], 64'h3);
            check("t6_w1",  got_data[1], 64'h71);
            check("t6_w2",  got_data[2], 64'h72);
            check("t6_eop", got_eop[2],  1'b1);
        end

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
